// File: rtl/pc_trace_streamer.sv
// pc_trace_streamer: captures committed (pc, instr) pairs into a FIFO and
// streams {seq, pc, instr} records over a valid/ready port. On halt it stops
// capturing, drains what is queued and then raises trace_done.
module pc_trace_streamer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 16,
  parameter int SEQ_WIDTH   = 8
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic                                      commit_valid,
  input  logic [ADDR_WIDTH-1:0]                     commit_pc,
  input  logic [INSTR_WIDTH-1:0]                    commit_instr,
  input  logic                                      halt,
  output logic                                      trace_valid,
  input  logic                                      trace_ready,
  output logic [SEQ_WIDTH+ADDR_WIDTH+INSTR_WIDTH-1:0] trace_data,
  output logic [$clog2(DEPTH):0]                    fill_level,
  output logic                                      overflow,
  output logic [SEQ_WIDTH-1:0]                      drop_count,
  output logic                                      trace_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = SEQ_WIDTH + ADDR_WIDTH + INSTR_WIDTH;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [RW-1:0]        mem [DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, count_nxt;
  logic [SEQ_WIDTH-1:0] seq;
  logic                 push_req, push, pop, full, drop;

  // A commit is eligible only while capturing; a full FIFO still accepts it
  // when the head leaves in the same cycle.
  assign push_req = (state == CAPTURE) && commit_valid;
  assign full     = (count == CW'(DEPTH));
  assign pop      = (count != '0) && trace_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;

  // Occupancy after this cycle's push/pop; also used to detect drain completion.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // Next-state: halt wins over enable; drain finishes the cycle the FIFO empties.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (halt) state_nxt = DRAIN; else if (enable) state_nxt = CAPTURE;
      CAPTURE: if (halt) state_nxt = DRAIN; else if (!enable) state_nxt = IDLE;
      DRAIN:   if (count_nxt == '0) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  // State, pointers, sequence number and drop accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // seq advances on dropped commits too so the sink can see the gap
      if (push_req) seq <= seq + SEQ_WIDTH'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + SEQ_WIDTH'(1);
      end
    end
  end

  // Record storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {seq, commit_pc, commit_instr};
  end

  assign trace_valid = (count != '0);
  assign trace_data  = trace_valid ? mem[rd_ptr] : '0;
  assign fill_level  = count;
  assign trace_done  = (state == DONE);
endmodule

// File: tb/tb_pc_trace_streamer.sv
// Directed bench for pc_trace_streamer: stimulus queues expected records,
// a negedge monitor pops and compares on every handshake.
module tb_pc_trace_streamer;
  logic        clock = 1'b0;
  logic        reset, enable, commit_valid, halt, trace_ready;
  logic [7:0]  commit_pc;
  logic [15:0] commit_instr;
  logic        trace_valid, overflow, trace_done;
  logic [31:0] trace_data;
  logic [4:0]  fill_level;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  pc_trace_streamer dut (
    .clock(clock), .reset(reset), .enable(enable), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .halt(halt),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count),
    .trace_done(trace_done)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [7:0] pc, input logic [15:0] ins,
                        input logic [7:0] s, input bit expect_it);
    commit_valid = 1'b1; commit_pc = pc; commit_instr = ins;
    if (expect_it) exp_q.push_back({s, pc, ins});
    step();
    commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; commit_valid = 1'b0; halt = 1'b0; trace_ready = 1'b0;
    commit_pc = '0; commit_instr = '0;
    exp_q.delete();
    step(); step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, trace_valid, 0);
    chk({tag, "_data"}, trace_data, 0);
    chk({tag, "_fill"}, fill_level, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_drops"}, drop_count, 0);
    chk({tag, "_done"}, trace_done, 0);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (fill_level == 0) break;
      step();
    end
    chk({tag, "_drained"}, fill_level, 0);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Monitor: stability while stalled, and in-order record matching on handshakes.
  logic        p_vld = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
  logic [31:0] p_data = '0;
  always @(negedge clock) begin
    if (!reset && !p_rst && p_vld && !p_rdy) begin
      chk("hold_valid", trace_valid, 1);
      chk("hold_data", trace_data, p_data);
    end
    if (!reset && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL record actual=%h required=none", trace_data);
      end else begin
        chk("record", trace_data, exp_q.pop_front());
      end
    end
    p_vld = trace_valid; p_rdy = trace_ready; p_rst = reset; p_data = trace_data;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state, then three commits each visible one cycle later
    do_reset();
    reset = 1'b1; step();
    chk_reset_outputs("reset");
    reset = 1'b0;
    enable = 1'b1; trace_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      commit(8'(i), 16'hA000 + 16'(i), 8'(i), 1'b1);
      chk("t1_valid", trace_valid, 1);
      chk("t1_data", trace_data, {8'(i), 8'(i), 16'hA000 + 16'(i)});
    end
    wait_empty("t1");

    // 3: full FIFO, pop and push in the same cycle is accepted
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 16; i++) commit(8'(i), 16'hC000 + 16'(i), 8'(i), 1'b1);
    chk("t3_full", fill_level, 16);
    trace_ready = 1'b1;
    commit(8'h40, 16'hC040, 8'd16, 1'b1);
    chk("t3_fill", fill_level, 16);
    chk("t3_ovf", overflow, 0);
    chk("t3_drops", drop_count, 0);
    wait_empty("t3");

    // 2: overflow drops the 17th commit; seq 16 never appears
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 16; i++) commit(8'(i), 16'hB000 + 16'(i), 8'(i), 1'b1);
    commit(8'h10, 16'hB010, 8'd16, 1'b0);
    chk("t2_fill", fill_level, 16);
    chk("t2_ovf", overflow, 1);
    chk("t2_drops", drop_count, 1);
    enable = 1'b0; trace_ready = 1'b1;
    wait_empty("t2");
    chk("t2_ovf_sticky", overflow, 1);

    // 4: halt with simultaneous commit, drain, done; later commits ignored
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 3; i++) commit(8'h20 + 8'(i), 16'hD000 + 16'(i), 8'(i), 1'b1);
    halt = 1'b1; trace_ready = 1'b1;
    commit_valid = 1'b1; commit_pc = 8'h2A; commit_instr = 16'hD02A;
    exp_q.push_back({8'd3, 8'h2A, 16'hD02A});
    step();
    halt = 1'b0; commit_pc = 8'h77; commit_instr = 16'hEEEE;  // held commit must be ignored
    chk("t4_fill_after_halt", fill_level, 3);
    chk("t4_not_done", trace_done, 0);
    for (int i = 0; i < 10; i++) begin
      if (fill_level == 0) break;
      step();
    end
    chk("t4_empty", fill_level, 0);
    chk("t4_done", trace_done, 1);
    chk("t4_queue_left", exp_q.size(), 0);
    step(); step();
    chk("t4_ignored", fill_level, 0);
    chk("t4_done_hold", trace_done, 1);
    commit_valid = 1'b0;

    // 5: ready toggling every cycle across a 5-record burst
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 5; i++) commit(8'h30 + 8'(i), 16'hF000 + 16'(i), 8'(i), 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (fill_level == 0) break;
      trace_ready = ~trace_ready;
      step();
    end
    trace_ready = 1'b0;
    wait_empty("t5");

    // 6: reset during drain discards everything; seq restarts at 0
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 5; i++) commit(8'h50 + 8'(i), 16'h1000 + 16'(i), 8'(i), 1'b1);
    halt = 1'b1; step(); halt = 1'b0;
    chk("t6_queued", fill_level, 5);
    reset = 1'b1;
    exp_q.delete();
    step();
    chk_reset_outputs("t6");
    reset = 1'b0; enable = 1'b1;
    step();
    commit(8'h55, 16'h5555, 8'd0, 1'b1);
    chk("t6_seq0", trace_data, {8'd0, 8'h55, 16'h5555});
    trace_ready = 1'b1;
    wait_empty("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
